seq_divider: RTL and testbench

- Iterative unsigned restoring divider; the inverse operation of the team's combinational array multipliers.
- Divides a 2W-bit dividend (multiplier-product width) by a W-bit divisor, producing a W-bit quotient and a W-bit remainder at one quotient bit per cycle.
- Sits beside the multiplier tree in the arithmetic datapath.
- Uses a valid/ready handshake on both input and output.

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_div_step.sv | 22 ++
 rtl/seq_divider.sv | 98 +++++++++
 tb/tb_seq_divider.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package seq_divider_pkg;

    localparam int unsigned DEF_W = 4;

    // Quotient reported on overflow or divide-by-zero; sliced to W by users.
    localparam logic [63:0] OVF_QUOT = '1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: (W+1)-bit trial subtract of the divisor from the
// shifted partial remainder, restoring the shifted value when the subtract would go negative.
module seq_divider_div_step #(
    parameter int unsigned W = seq_divider_pkg::DEF_W
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] y,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;

    always_comb begin
        // Keep the full W+1 bits: the shifted remainder can carry out before the subtract.
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, y});
        rem_out = q_bit ? W'(shifted - {1'b0, y}) : shifted[W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per cycle, valid/ready handshake on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] x,
    input  logic [W-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r,
    output logic           err
);

    localparam int unsigned CW = $clog2(W);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  ydiv;
    logic [W-1:0]  rem_nxt;
    logic          q_bit;

    seq_divider_div_step #(
        .W (W)
    ) u_step (
        .rem_in  (rem),
        .bit_in  (quo[W-1]),
        .y       (ydiv),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign in_ready = (state == StIdle) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            ydiv      <= '0;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        ydiv <= y;
                        // A high half >= divisor means the quotient cannot fit in W bits.
                        if (y == '0 || x[2*W-1:W] >= y) begin
                            q         <= OVF_QUOT[W-1:0];
                            r         <= x[W-1:0];
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end else begin
                            rem   <= x[2*W-1:W];
                            quo   <= x[W-1:0];
                            cnt   <= CW'(W - 1);
                            err   <= 1'b0;
                            state <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem <= rem_nxt;
                    quo <= {quo[W-2:0], q_bit};
                    if (cnt == '0) begin
                        q         <= {quo[W-2:0], q_bit};
                        r         <= rem_nxt;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at W=4 against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] x;
    logic [W-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           err;

    int tests = 0;
    int fails = 0;

    seq_divider #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; anything not fitting a W-bit quotient is an error.
    function automatic void ref_div(input int xv, input int yv, output logic [3:0] qe,
                                    output logic [3:0] re, output logic ee, output int le);
        if (yv == 0 || (xv / yv) > 15) begin
            qe = 4'hF;
            re = 4'(xv % 16);
            ee = 1'b1;
            le = 1;
        end else begin
            qe = 4'(xv / yv);
            re = 4'(xv % yv);
            ee = 1'b0;
            le = W + 1;
        end
    endfunction

    // Drives one operation; lat counts clock edges from the accept edge (inclusive).
    task automatic run_op(input logic [7:0] xi, input logic [3:0] yi, input int hold,
                          output logic [3:0] qo, output logic [3:0] ro, output logic eo,
                          output int lat, output bit tmo);
        int guard;
        tmo = 1'b0;
        lat = 0;
        qo  = '0;
        ro  = '0;
        eo  = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        x        = xi;
        y        = yi;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            tmo      = 1'b1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x        = 8'($urandom);
        y        = 4'($urandom);
        lat      = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        qo = q;
        ro = r;
        eo = err;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || q !== 4'h0 || r !== 4'h0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b q=%h r=%h err=%b, want 0 0 0 0 0",
                     in_ready, out_valid, q, r, err);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] xi, input logic [3:0] yi,
                            input int hold);
        logic [3:0] qo, ro, qe, re;
        logic       eo, ee;
        int         lat, le;
        bit         tmo;
        ref_div(int'(xi), int'(yi), qe, re, ee, le);
        run_op(xi, yi, hold, qo, ro, eo, lat, tmo);
        tests++;
        if (tmo || qo !== qe || ro !== re || eo !== ee || lat != le) begin
            fails++;
            $display("FAIL %s x=%h y=%h: got q=%h r=%h err=%b lat=%0d tmo=%0d, want q=%h r=%h err=%b lat=%0d",
                     name, xi, yi, qo, ro, eo, lat, tmo, qe, re, ee, le);
        end
    endtask

    task automatic test_basic();
        logic [7:0] xs[3] = '{8'h2A, 8'hE1, 8'h75};
        logic [3:0] ys[3] = '{4'h5, 4'hF, 4'hB};
        for (int i = 0; i < 3; i++) check_op("basic", xs[i], ys[i], 0);
    endtask

    task automatic test_overflow();
        check_op("div_by_zero", 8'h33, 4'h0, 0);
        check_op("high_ge_div", 8'h50, 4'h5, 0);
        check_op("high_eq_div_max", 8'hFF, 4'hF, 1);
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        x        = 8'h2A;
        y        = 4'h5;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            x        = 8'h63;
            y        = 4'h7;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== 4'h8 || r !== 4'h2 || err !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b q=%h r=%h err=%b, want 1 0 8 2 0",
                         i, out_valid, in_ready, q, r, err);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 4'h8) begin
            fails++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b q=%h, want 0 1 8",
                     out_valid, in_ready, q);
        end
        check_op("after_backpressure", 8'h63, 4'h7, 0);
    endtask

    task automatic test_reset_mid_run();
        int  guard;
        bit  spurious;
        @(negedge clk);
        in_valid = 1'b1;
        x        = 8'h2A;
        y        = 4'h5;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || q !== 4'h0 || r !== 4'h0 || err !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run: out_valid=%b q=%h r=%h err=%b in_ready=%b, want 0 0 0 0 0",
                     out_valid, q, r, err, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_run_ready: in_ready=%b want 1", in_ready);
        end
        spurious = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious = 1'b1;
        end
        tests++;
        if (spurious) begin
            fails++;
            $display("FAIL reset_mid_run_no_result: out_valid rose after abort, want 0");
        end
        check_op("after_reset", 8'h2A, 4'h5, 0);
    endtask

    task automatic test_random_sweep();
        logic [3:0] qo, ro, qe, re;
        logic       eo, ee;
        int         lat, le;
        bit         tmo;
        for (int yv = 1; yv < 16; yv++) begin
            for (int xv = 0; xv < 256; xv++) begin
                if ((xv >> 4) < yv) begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    run_op(8'(xv), 4'(yv), $urandom_range(0, 2), qo, ro, eo, lat, tmo);
                    ref_div(xv, yv, qe, re, ee, le);
                    tests++;
                    if (tmo || eo !== 1'b0 || lat != W + 1 ||
                        int'(qo) * yv + int'(ro) != xv || int'(ro) >= yv ||
                        qo !== qe || ro !== re) begin
                        fails++;
                        $display("FAIL sweep x=%h y=%h: got q=%h r=%h err=%b lat=%0d tmo=%0d, want q=%h r=%h err=0 lat=%0d",
                                 8'(xv), 4'(yv), qo, ro, eo, lat, tmo, qe, re, W + 1);
                    end
                end
            end
        end
        // Random pairs including overflow and divide-by-zero.
        for (int i = 0; i < 200; i++) begin
            check_op("random", 8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
